// File: rtl/img_match_sad.sv
// img_match_sad: per-frame windowed SAD between the live grey stream and the template look-up stage.
// Optional IMG_MATCH_EARLY_ABORT_EN freezes accumulation once the SAD passes the latched threshold.
module img_match_sad #(
  parameter int LAT   = 3,
  parameter int WIN_W = 256,
  parameter int WIN_H = 256,
  parameter int SAD_W = 26
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [12:0]      iX,
  input  logic [12:0]      iY,
  input  logic [9:0]       iGRAY,
  input  logic [12:0]      iORG_X,
  input  logic [12:0]      iORG_Y,
  input  logic [SAD_W-1:0] iTHRESH,
  output logic [12:0]      oSRCH_X,
  output logic [12:0]      oSRCH_Y,
  input  logic [9:0]       iSRCH_VAL,
  output logic [SAD_W-1:0] oSAD,
  output logic             oSAD_VALID,
  output logic             oMATCH,
  output logic             oBUSY
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;
  localparam logic [16:0] AREA  = 17'(WIN_W * WIN_H);

  logic [1:0]          state;
  logic                fvalD;
  logic [12:0]         orgX, orgY;
  logic [SAD_W-1:0]    thrL, acc;
  logic [16:0]         cnt;
  logic [7:0]          drainCnt;
  logic [LAT:0][9:0]   grayPipe;
  logic [LAT:0]        vldPipe;
  logic [13:0]         dx, dy;
  logic                inwin, rise, fall, frozen;
  logic [10:0]         diff;
  logic [9:0]          absDiff;

  assign rise  = iFVAL & ~fvalD;
  assign fall  = ~iFVAL & fvalD;
  assign dx    = {1'b0, iX} - {1'b0, orgX};
  assign dy    = {1'b0, iY} - {1'b0, orgY};
  assign inwin = iDVAL && (state == ACCUM) &&
                 !dx[13] && (dx < 14'(WIN_W)) && !dy[13] && (dy < 14'(WIN_H));
  assign diff    = {1'b0, grayPipe[LAT]} - {1'b0, iSRCH_VAL};
  assign absDiff = diff[10] ? 10'(-diff) : diff[9:0];
  assign oBUSY   = (state == ACCUM) || (state == DRAIN);

`ifdef IMG_MATCH_EARLY_ABORT_EN
  assign frozen = (acc > thrL);
`else
  assign frozen = 1'b0;
`endif

  // Live pixel and its in-window flag ride 1+LAT stages so they meet the looked-up template value.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      grayPipe <= '0;
      vldPipe  <= '0;
      oSRCH_X  <= '0;
      oSRCH_Y  <= '0;
    end else begin
      grayPipe <= {grayPipe[LAT-1:0], iGRAY};
      vldPipe  <= {vldPipe[LAT-1:0], inwin};
      oSRCH_X  <= inwin ? dx[12:0] : 13'd0;
      oSRCH_Y  <= inwin ? dy[12:0] : 13'd0;
    end
  end

  // fvalD resets high so a reset released mid-frame does not look like a frame start.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state      <= IDLE;
      fvalD      <= 1'b1;
      orgX       <= '0;
      orgY       <= '0;
      thrL       <= '0;
      acc        <= '0;
      cnt        <= '0;
      drainCnt   <= '0;
      oSAD       <= '0;
      oSAD_VALID <= 1'b0;
      oMATCH     <= 1'b0;
    end else begin
      fvalD      <= iFVAL;
      oSAD_VALID <= 1'b0;
      if (vldPipe[LAT] && !frozen) begin
        acc <= acc + SAD_W'(absDiff);
        cnt <= cnt + 17'd1;
      end
      case (state)
        IDLE: if (rise) begin
          state <= ACCUM;
          orgX  <= iORG_X;
          orgY  <= iORG_Y;
          thrL  <= iTHRESH;
          acc   <= '0;
          cnt   <= '0;
        end
        ACCUM: if (fall) begin
          state    <= DRAIN;
          drainCnt <= '0;
        end
        DRAIN: begin
          if (drainCnt == 8'(LAT)) state <= REPORT;
          else drainCnt <= drainCnt + 8'd1;
        end
        default: begin
          oSAD       <= acc;
          oMATCH     <= (cnt == AREA) && (acc <= thrL);
          oSAD_VALID <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_img_match_sad.sv
// tb_img_match_sad: directed frames with hashed/random pixels against a frame-level SAD model and a 3-cycle look-up model.
module tb_img_match_sad;
  localparam int LAT   = 3;
  localparam int WIN_W = 32;
  localparam int WIN_H = 32;
  localparam int SAD_W = 21;
  localparam int SC    = WIN_W / 16;
  localparam int FW    = 48;
  localparam int FH    = 40;
  localparam longint HUGE = (64'd1 << SAD_W) - 1;

  logic             iCLK, iRST, iFVAL, iDVAL;
  logic [12:0]      iX, iY, iORG_X, iORG_Y;
  logic [9:0]       iGRAY, iSRCH_VAL;
  logic [SAD_W-1:0] iTHRESH, oSAD;
  logic [12:0]      oSRCH_X, oSRCH_Y;
  logic             oSAD_VALID, oMATCH, oBUSY;

  img_match_sad #(.LAT(LAT), .WIN_W(WIN_W), .WIN_H(WIN_H), .SAD_W(SAD_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iX(iX), .iY(iY),
    .iGRAY(iGRAY), .iORG_X(iORG_X), .iORG_Y(iORG_Y), .iTHRESH(iTHRESH),
    .oSRCH_X(oSRCH_X), .oSRCH_Y(oSRCH_Y), .iSRCH_VAL(iSRCH_VAL), .oSAD(oSAD),
    .oSAD_VALID(oSAD_VALID), .oMATCH(oMATCH), .oBUSY(oBUSY));

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int tmpl [16][16];
  int nVec = 0, nFail = 0;

  function automatic int tmplAt(input int x, input int y);
    int xi, yi;
    xi = x / SC; yi = y / SC;
    if (xi > 15) xi = 15;
    if (yi > 15) yi = 15;
    return tmpl[yi][xi];
  endfunction

  // Look-up stage: three registers from search coordinates to template value.
  int sr0 = 0, sr1 = 0, sr2 = 0;
  always @(posedge iCLK) begin
    sr0 <= tmplAt(int'(oSRCH_X), int'(oSRCH_Y));
    sr1 <= sr0;
    sr2 <= sr1;
  end
  assign iSRCH_VAL = 10'(sr2);

  int cyc = 0, pulses = 0, pulseCyc = -1;
  logic [SAD_W-1:0] pSad = '0;
  logic pMatch = 1'b0;
  always @(posedge iCLK) cyc <= cyc + 1;
  always @(negedge iCLK) if (oSAD_VALID === 1'b1) begin
    pulses   <= pulses + 1;
    pulseCyc <= cyc;
    pSad     <= oSAD;
    pMatch   <= oMATCH;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hashPix(input int x, input int y, input int seed);
    int h;
    h = (x * 1103 + y * 2029 + seed * 7919) ^ (x * y * 31);
    return h & 1023;
  endfunction

  function automatic bit inWin(input int x, input int y, input int ox, input int oy);
    return (x - ox >= 0) && (x - ox < WIN_W) && (y - oy >= 0) && (y - oy < WIN_H);
  endfunction

  // gm: 0 matched, 1 hashed, 2 matched+/-1, 3 all zero
  function automatic int grayOf(input int x, input int y, input int ox, input int oy, input int gm, input int seed);
    int t;
    bit w;
    w = inWin(x, y, ox, oy);
    t = w ? tmpl[(y - oy) / SC][(x - ox) / SC] : 0;
    case (gm)
      0: return w ? t : hashPix(x, y, seed);
      2: return w ? ((t < 1023) ? t + 1 : t - 1) : hashPix(x, y, seed);
      3: return 0;
      default: return hashPix(x, y, seed);
    endcase
  endfunction

  function automatic bit dvalOf(input int x, input int dm);
    return (dm == 1) ? (x % 2 == 0) : 1'b1;
  endfunction

  // Frame-level reference: raster-order SAD and pixel count over the window.
  task automatic preSad(input int ox, input int oy, input int gm, input int dm, input int seed,
                        input longint thr, output longint sad, output longint cnt);
    int d;
    sad = 0; cnt = 0;
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        if (dvalOf(x, dm) && inWin(x, y, ox, oy)) begin
`ifdef IMG_MATCH_EARLY_ABORT_EN
          if (sad > thr) continue;
`endif
          d = grayOf(x, y, ox, oy, gm, seed) - tmpl[(y - oy) / SC][(x - ox) / SC];
          sad += (d < 0) ? -d : d;
          cnt++;
        end
  endtask

  bit active = 0;
  int expX = 0, expY = 0, curOx = 0, curOy = 0, fallCyc = 0;

  task automatic step(input bit fv, input bit dv, input int x, input int y, input int g);
    @(posedge iCLK); #1;
    iFVAL = fv; iDVAL = dv; iX = 13'(x); iY = 13'(y); iGRAY = 10'(g);
    @(negedge iCLK);
    chk("srchX", oSRCH_X, expX);
    chk("srchY", oSRCH_Y, expY);
    if (dv && active && inWin(x, y, curOx, curOy)) begin
      expX = x - curOx; expY = y - curOy;
    end else begin
      expX = 0; expY = 0;
    end
  endtask

  task automatic rise(input int ox, input int oy, input longint thr, input bit accept);
    iORG_X = 13'(ox); iORG_Y = 13'(oy); iTHRESH = SAD_W'(thr);
    step(1, 0, 0, 0, 0);
    active = accept;
    if (accept) begin curOx = ox; curOy = oy; end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic body(input int ox, input int oy, input int gm, input int dm, input int seed, input int rstAt);
    int idx;
    idx = 0;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        step(1, dvalOf(x, dm), x, y, grayOf(x, y, ox, oy, gm, seed));
        if (idx == rstAt) begin
          iRST = 1'b0; #1;
          chk("rstSad", oSAD, 0);
          chk("rstValid", oSAD_VALID, 0);
          chk("rstMatch", oMATCH, 0);
          chk("rstBusy", oBUSY, 0);
          chk("rstSrchX", oSRCH_X, 0);
          chk("rstSrchY", oSRCH_Y, 0);
          active = 0; expX = 0; expY = 0;
          @(posedge iCLK); @(negedge iCLK);
          iRST = 1'b1;
        end
        idx++;
      end
      step(1, 0, 0, 0, 0);
    end
  endtask

  task automatic fall();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    active = 0;
    fallCyc = cyc;
  endtask

  task automatic checkReport(input string tag, input bit expPulse, input int base, input int fc,
                             input longint sad, input bit match);
    repeat (12) step(0, 0, 0, 0, 0);
    chk({tag, "_pulses"}, 64'(pulses - base), expPulse ? 1 : 0);
    if (expPulse) begin
      chk({tag, "_latency"}, 64'(pulseCyc - fc), LAT + 3);
      chk({tag, "_sad"}, pSad, sad);
      chk({tag, "_match"}, pMatch, match);
      chk({tag, "_sadHeld"}, oSAD, sad);
      chk({tag, "_matchHeld"}, oMATCH, match);
    end
    chk({tag, "_busy"}, oBUSY, 0);
  endtask

  task automatic runFrame(input string tag, input int ox, input int oy, input longint thr,
                          input int gm, input int dm, input int seed);
    longint s, c;
    int base;
    preSad(ox, oy, gm, dm, seed, thr, s, c);
    base = pulses;
    rise(ox, oy, thr, 1);
    body(ox, oy, gm, dm, seed, -1);
    fall();
    checkReport(tag, 1, base, fallCyc, s, (c == WIN_W * WIN_H) && (s <= thr));
  endtask

  initial begin
    longint s, c, sA, cA;
    int base, fcA;
    iRST = 1'b0; iFVAL = 0; iDVAL = 0; iX = 0; iY = 0; iGRAY = 0;
    iORG_X = 0; iORG_Y = 0; iTHRESH = 0;
    for (int r = 0; r < 16; r++)
      for (int q = 0; q < 16; q++) tmpl[r][q] = int'($urandom_range(0, 1023));
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("resetSad", oSAD, 0);
    chk("resetValid", oSAD_VALID, 0);
    chk("resetMatch", oMATCH, 0);
    chk("resetBusy", oBUSY, 0);
    chk("resetSrchX", oSRCH_X, 0);
    chk("resetSrchY", oSRCH_Y, 0);
    iRST = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0);

    runFrame("matched", 8, 4, 0, 0, 0, 1);
    preSad(10, 6, 1, 0, 2, HUGE, s, c);
    runFrame("thrEqual", 10, 6, s, 1, 0, 2);
    runFrame("thrBelow", 10, 6, s - 1, 1, 0, 2);
    runFrame("zeroGray", 0, 0, 1000000, 3, 0, 3);
    runFrame("edgeX", FW - 10, 4, 0, 0, 0, 4);
    runFrame("corner", 20, 12, HUGE, 1, 0, 5);
    runFrame("dvalHalf", 8, 8, HUGE, 2, 1, 6);
    chk("dvalSadIsCount", pSad, WIN_W * WIN_H / 2);

    base = pulses;
    rise(8, 4, 0, 1);
    body(8, 4, 0, 0, 7, 300);
    fall();
    checkReport("midReset", 0, base, fallCyc, 0, 0);
    runFrame("afterReset", 8, 4, 0, 0, 0, 7);

    preSad(5, 5, 1, 0, 8, HUGE, sA, cA);
    base = pulses;
    rise(5, 5, HUGE, 1);
    body(5, 5, 1, 0, 8, -1);
    fall();
    fcA = fallCyc;
    rise(0, 0, 0, 0);
    body(0, 0, 1, 0, 9, -1);
    fall();
    checkReport("reRise", 1, base, fcA, sA, cA == WIN_W * WIN_H);
    runFrame("afterSkip", 12, 2, HUGE, 1, 0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
